// File: rtl/lsu_bus_master.sv
// lsu_bus_master: turns core load/store requests into single transactions on a word bus
//
// Optional feature: define BUS_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT_CYCLES
// cycles without ack (the access then completes with o_rsp_err=1).
//
// Ports:
//   i_clk, i_reset     clock, asynchronous active-high reset
//   i_req_*            core request (valid, addr, write, size, unsigned, wdata)
//   o_req_ready        high while idle and able to accept a request
//   o_rsp_*            one-cycle completion pulse with extended load data and error flag
//   o_dev_sel, o_addr, o_sel, o_write, o_data   bus request, one cycle per transaction
//   i_ack, i_data      responder acknowledge and read data
module lsu_bus_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic                  i_req_write,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_unsigned,
    input  logic [31:0]           i_req_wdata,
    output logic                  o_rsp_valid,
    output logic [31:0]           o_rsp_data,
    output logic                  o_rsp_err,
    output logic                  o_dev_sel,
    output logic [ADDR_WIDTH-3:0] o_addr,
    output logic [3:0]            o_sel,
    output logic                  o_write,
    output logic [31:0]           o_data,
    input  logic                  i_ack,
    input  logic [31:0]           i_data
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    state_t state_q, state_d;
    logic [1:0] off_q, off_d, size_q, size_d;
    logic uns_q, uns_d, we_q, we_d;
    logic rdy_q, rdy_d, dev_sel_q, dev_sel_d, wr_q, wr_d;
    logic [ADDR_WIDTH-3:0] addr_q, addr_d;
    logic [3:0] sel_q, sel_d;
    logic [31:0] data_q, data_d, rsp_data_q, rsp_data_d, sh;
    logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, bad;
`ifdef BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif
    assign o_req_ready = rdy_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_dev_sel   = dev_sel_q;
    assign o_addr      = addr_q;
    assign o_sel       = sel_q;
    assign o_write     = wr_q;
    assign o_data      = data_q;
    assign bad = (i_req_size == 2'b11) || (i_req_size == 2'b01 && i_req_addr[0]) ||
                 (i_req_size == 2'b10 && i_req_addr[1:0] != 2'b00);
    always_comb begin
        state_d    = state_q;
        off_d      = off_q;
        size_d     = size_q;
        uns_d      = uns_q;
        we_d       = we_q;
        dev_sel_d  = 1'b0;
        wr_d       = 1'b0;
        addr_d     = addr_q;
        sel_d      = sel_q;
        data_d     = data_q;
        rsp_err_d  = 1'b0;
        rsp_data_d = 32'h0;
        sh         = i_data >> {off_q, 3'b000};
`ifdef BUS_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE: if (i_req_valid && rdy_q) begin
                off_d  = i_req_addr[1:0];
                size_d = i_req_size;
                uns_d  = i_req_unsigned;
                we_d   = i_req_write;
                if (bad) begin
                    state_d   = RESP;
                    rsp_err_d = 1'b1;
                end else begin
                    state_d   = REQ;
                    dev_sel_d = 1'b1;
                    wr_d      = i_req_write;
                    addr_d    = i_req_addr[ADDR_WIDTH-1:2];
                    sel_d     = i_req_size == 2'b00 ? 4'b0001 << i_req_addr[1:0] :
                                i_req_size == 2'b01 ? 4'b0011 << i_req_addr[1:0] : 4'b1111;
                    data_d    = i_req_size == 2'b00 ? {4{i_req_wdata[7:0]}} :
                                i_req_size == 2'b01 ? {2{i_req_wdata[15:0]}} : i_req_wdata;
                end
            end
            REQ: begin
                state_d = WAIT;
`ifdef BUS_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: if (i_ack) begin
                state_d    = RESP;
                rsp_data_d = we_q ? 32'h0 :
                             size_q == 2'b00 ? {{24{sh[7] & ~uns_q}}, sh[7:0]} :
                             size_q == 2'b01 ? {{16{sh[15] & ~uns_q}}, sh[15:0]} : sh;
            end
`ifdef BUS_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                state_d   = RESP;
                rsp_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
`endif
            default: state_d = IDLE;
        endcase
        rsp_valid_d = state_d == RESP;
        rdy_d       = state_d == IDLE;
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            off_q       <= 2'b00;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            we_q        <= 1'b0;
            rdy_q       <= 1'b0;
            dev_sel_q   <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            sel_q       <= 4'h0;
            data_q      <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 32'h0;
`ifdef BUS_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            we_q        <= we_d;
            rdy_q       <= rdy_d;
            dev_sel_q   <= dev_sel_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            sel_q       <= sel_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
`ifdef BUS_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_lsu_bus_master.sv
// tb_lsu_bus_master: directed and randomized checks of lsu_bus_master against a byte-level model
module tb_lsu_bus_master;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, req_uns = 1'b0, ack = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0, bus_rdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_ready, rsp_valid, rsp_err, dev_sel, bus_write;
    logic [31:0] rsp_data, bus_wdata;
    logic [29:0] bus_addr;
    logic [3:0]  bus_sel;
    int          total = 0, passed = 0;

    lsu_bus_master dut (
        .i_clk(clk), .i_reset(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_addr(req_addr), .i_req_write(req_write), .i_req_size(req_size),
        .i_req_unsigned(req_uns), .i_req_wdata(req_wdata), .o_rsp_valid(rsp_valid),
        .o_rsp_data(rsp_data), .o_rsp_err(rsp_err), .o_dev_sel(dev_sel), .o_addr(bus_addr),
        .o_sel(bus_sel), .o_write(bus_write), .o_data(bus_wdata), .i_ack(ack), .i_data(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic bit ref_bad(input logic [31:0] a, input logic [1:0] sz);
        int n = 1 << sz;
        return sz == 2'b11 || (a % n) != 0;
    endfunction

    function automatic logic [3:0] ref_sel(input logic [1:0] off, input logic [1:0] sz);
        logic [3:0] r = '0;
        int n = 1 << sz;
        for (int b = 0; b < 4; b++) r[b] = (b >= off) && (b < off + n);
        return r;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input logic [1:0] sz);
        logic [31:0] r;
        int n = 1 << sz;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = wd[8*(b % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] off,
                                             input logic [1:0] sz, input bit u);
        int n = 1 << sz;
        longint v = (longint'(rd) >> (8 * off)) & ((64'd1 << (8 * n)) - 1);
        if (!u && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    // one complete access: acceptance, bus request, dly extra WAIT cycles, response
    task automatic txn(input logic [31:0] a, input bit w, input logic [1:0] sz, input bit u,
                       input logic [31:0] wd, input logic [31:0] rd, input int dly);
        @(negedge clk);
        chk("ready_before", req_ready, 1);
        req_valid = 1; req_addr = a; req_write = w; req_size = sz; req_uns = u; req_wdata = wd;
        @(negedge clk);
        req_valid = 0;
        if (ref_bad(a, sz)) begin
            chk("err_no_sel", dev_sel, 0);
            chk("err_valid", rsp_valid, 1);
            chk("err_flag", rsp_err, 1);
            chk("err_data", rsp_data, 0);
        end else begin
            chk("req_sel", dev_sel, 1);
            chk("req_write", bus_write, w);
            chk("req_addr", bus_addr, a[31:2]);
            chk("req_lanes", bus_sel, ref_sel(a[1:0], sz));
            chk("req_wdata", bus_wdata, ref_wdata(wd, sz));
            chk("req_ready", req_ready, 0);
            for (int i = 0; i <= dly; i++) begin
                @(negedge clk);
                chk("wait_sel", {dev_sel, bus_write, rsp_valid}, 0);
            end
            ack = 1; bus_rdata = rd;
            @(negedge clk);
            ack = 0; bus_rdata = $urandom;
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_err", rsp_err, 0);
            chk("rsp_data", rsp_data, w ? 32'h0 : ref_load(rd, a[1:0], sz, u));
        end
        @(negedge clk);
        chk("rsp_done", {rsp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_outs", {req_ready, rsp_valid, rsp_err, dev_sel, bus_write, bus_sel}, 0);
        chk("rst_data", bus_wdata | rsp_data | 32'(bus_addr), 0);
        rst = 0;
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        txn(32'h10, 1, 2'b10, 0, 32'hDEADBEEF, 0, 0);
        txn(32'h13, 1, 2'b00, 0, 32'h000000A5, 0, 0);
        txn(32'h12, 1, 2'b01, 0, 32'h00001234, 0, 1);
        txn(32'h02, 0, 2'b00, 0, 0, 32'h80FF7F01, 0);
        chk("plan_sb", rsp_data, 32'h0);
        txn(32'h03, 0, 2'b00, 1, 0, 32'h80FF7F01, 2);
        txn(32'h00, 0, 2'b01, 0, 0, 32'h80FF7F01, 0);
        txn(32'h02, 0, 2'b01, 0, 0, 32'h80FF7F01, 0);
        txn(32'h06, 0, 2'b10, 0, 0, 0, 0);
        txn(32'h01, 0, 2'b01, 0, 0, 0, 0);
        txn(32'h08, 1, 2'b11, 0, 32'h55, 0, 0);
        ack = 1;
        @(negedge clk);
        ack = 0;
        chk("stray_ack", {rsp_valid, dev_sel, req_ready}, 3'b001);
        // long WAIT with no ack
        @(negedge clk);
        req_valid = 1; req_addr = 32'h20; req_write = 0; req_size = 2'b10; req_uns = 0;
        @(negedge clk);
        req_valid = 0;
        chk("long_sel", dev_sel, 1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("long_wait", {rsp_valid, req_ready}, 0);
        end
`ifdef BUS_TIMEOUT_EN
        @(negedge clk);
        chk("to_valid", rsp_valid, 1);
        chk("to_err", rsp_err, 1);
        chk("to_data", rsp_data, 0);
        repeat (2) @(negedge clk);
        ack = 1; bus_rdata = 32'h12345678;
        @(negedge clk);
        ack = 0;
        chk("late_ack", {rsp_valid, dev_sel, req_ready}, 3'b001);
`else
        repeat (10) begin
            @(negedge clk);
            chk("still_wait", {rsp_valid, req_ready}, 0);
        end
        ack = 1; bus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        ack = 0;
        chk("long_valid", {rsp_valid, rsp_err}, 2'b10);
        chk("long_data", rsp_data, 32'hCAFEF00D);
        @(negedge clk);
        chk("long_done", req_ready, 1);
`endif
        // reset while waiting
        @(negedge clk);
        req_valid = 1; req_addr = 32'h44; req_write = 1; req_size = 2'b10; req_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        rst = 1;
        #1;
        chk("arst_outs", {req_ready, rsp_valid, rsp_err, dev_sel, bus_write, bus_sel}, 0);
        chk("arst_data", bus_wdata | rsp_data | 32'(bus_addr), 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1);
        ack = 1;
        @(negedge clk);
        ack = 0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_quiet", {rsp_valid, dev_sel, req_ready}, 3'b001);
        end
        for (int i = 0; i < 60; i++)
            txn({$urandom_range(0, 255), 2'(($urandom_range(0, 3)))} & 32'h3FF, 1'($urandom),
                2'($urandom), 1'($urandom), $urandom, $urandom, $urandom_range(0, 3));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
